// File: rtl/logic_e_pkg.sv
// Shared definitions for the LUT logic element: output-stage modes and
// configuration-word field offsets.
package logic_e_pkg;

    typedef enum logic [1:0] {
        MODE_COMB = 2'b00,
        MODE_DFF  = 2'b01,
        MODE_TFF  = 2'b10,
        MODE_HOLD = 2'b11
    } le_mode_e;

    // Truth table occupies the low 2^K bits of the word.
    function automatic int tt_lsb();
        return 0;
    endfunction

    function automatic int tt_width(input int k);
        return 1 << k;
    endfunction

    // Select field j sits just above the truth table, packed LSB-first.
    function automatic int sel_lsb(input int k, input int sel_w, input int j);
        return (1 << k) + j * sel_w;
    endfunction

    function automatic int mode_lsb(input int k, input int sel_w);
        return (1 << k) + k * sel_w;
    endfunction

    // Init bit is the MSB, so it is the first bit shifted into the chain.
    function automatic int init_bit(input int k, input int sel_w);
        return (1 << k) + k * sel_w + 2;
    endfunction

    function automatic int cfg_width(input int k, input int sel_w);
        return (1 << k) + k * sel_w + 3;
    endfunction

endpackage

// File: rtl/logic_e_cfg_chain.sv
// Double-buffered serial configuration store: a shadow shift register that
// daisy-chains between elements and an active word updated only on commit.
module logic_e_cfg_chain #(
    parameter int CFG_W = 43
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_en_i,
    input  logic             cfg_din_i,
    input  logic             cfg_load_i,
    output logic [CFG_W-1:0] active_o,
    output logic             cfg_valid_o,
    output logic             cfg_dout_o,
    output logic             shadow_init_o
);

    logic [CFG_W-1:0] shadow_q, shadow_d;
    logic [CFG_W-1:0] active_q, active_d;
    logic             valid_q, valid_d;

    // Next-state: shift and commit are independent, and the commit always
    // samples the shadow as it stood before this edge.
    always_comb begin
        shadow_d = shadow_q;
        active_d = active_q;
        valid_d  = valid_q;
        if (cfg_en_i) begin
            shadow_d = {shadow_q[CFG_W-2:0], cfg_din_i};
        end
        if (cfg_load_i) begin
            active_d = shadow_q;
            valid_d  = 1'b1;
        end
    end

    // Configuration registers, cleared asynchronously.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shadow_q <= '0;
            active_q <= '0;
            valid_q  <= 1'b0;
        end else begin
            shadow_q <= shadow_d;
            active_q <= active_d;
            valid_q  <= valid_d;
        end
    end

    assign active_o      = active_q;
    assign cfg_valid_o   = valid_q;
    assign cfg_dout_o    = shadow_q[CFG_W-1];
    assign shadow_init_o = shadow_q[CFG_W-1];

endmodule

// File: rtl/logic_e_lut.sv
// K-input LUT logic element: routed input muxes, truth-table lookup and a
// configurable output stage (comb / DFF / TFF / hold), configured through a
// double-buffered serial chain.
module logic_e_lut
    import logic_e_pkg::*;
#(
    parameter int K          = 4,
    parameter int NUM_INPUTS = 33,
    parameter int SEL_W      = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_INPUTS-1:0] all_inputs,
    input  logic                  cfg_en,
    input  logic                  cfg_din,
    input  logic                  cfg_load,
    output logic                  cfg_dout,
    output logic                  cfg_valid,
    output logic                  leOut
);

    localparam int TT_W  = tt_width(K);
    localparam int CFG_W = cfg_width(K, SEL_W);
    localparam int TT_LO = tt_lsb();
    localparam int MD_LO = mode_lsb(K, SEL_W);

    logic [CFG_W-1:0] active_w;
    logic             valid_w;
    logic             shadow_init_w;
    logic [TT_W-1:0]  tt_w;
    le_mode_e         mode_w;
    logic [K-1:0]     idx_w;
    logic             f_w;
    logic             q_q, q_d;

    logic_e_cfg_chain #(
        .CFG_W(CFG_W)
    ) u_cfg (
        .clk          (clk),
        .rst          (rst),
        .cfg_en_i     (cfg_en),
        .cfg_din_i    (cfg_din),
        .cfg_load_i   (cfg_load),
        .active_o     (active_w),
        .cfg_valid_o  (valid_w),
        .cfg_dout_o   (cfg_dout),
        .shadow_init_o(shadow_init_w)
    );

    assign tt_w   = active_w[TT_LO +: TT_W];
    assign mode_w = le_mode_e'(active_w[MD_LO +: 2]);

    // Input routing: each LUT input picks one bus bit; selects beyond the
    // bus width read as 0 rather than wrapping or indexing out of range.
    always_comb begin
        idx_w = '0;
        for (int j = 0; j < K; j++) begin
            for (int i = 0; i < NUM_INPUTS; i++) begin
                if (active_w[sel_lsb(K, SEL_W, j) +: SEL_W] == SEL_W'(i)) begin
                    idx_w[j] = all_inputs[i];
                end
            end
        end
    end

    assign f_w = tt_w[idx_w];

    // Output-stage next state; a commit loads the init bit and overrides the
    // mode update in the same cycle.
    always_comb begin
        q_d = q_q;
        if (cfg_load) begin
            q_d = shadow_init_w;
        end else if (valid_w) begin
            case (mode_w)
                MODE_DFF: q_d = f_w;
                MODE_TFF: q_d = q_q ^ f_w;
                default:  q_d = q_q;
            endcase
        end
    end

    // Output-stage state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_q <= 1'b0;
        end else begin
            q_q <= q_d;
        end
    end

    // Output forced low until the first commit; comb mode bypasses q.
    always_comb begin
        leOut = 1'b0;
        if (valid_w) begin
            leOut = (mode_w == MODE_COMB) ? f_w : q_q;
        end
    end

    assign cfg_valid = valid_w;

endmodule

// File: tb/tb_logic_e_lut.sv
module tb_logic_e_lut;

    localparam int CFG_W = 43;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [32:0] all_inputs = '0;
    logic        cfg_en = 1'b0;
    logic        cfg_din = 1'b0;
    logic        cfg_load = 1'b0;
    logic        dout0, dout1, valid0, valid1, le0, le1;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    logic_e_lut u_dut0 (
        .clk(clk), .rst(rst), .all_inputs(all_inputs),
        .cfg_en(cfg_en), .cfg_din(cfg_din), .cfg_load(cfg_load),
        .cfg_dout(dout0), .cfg_valid(valid0), .leOut(le0)
    );

    logic_e_lut u_dut1 (
        .clk(clk), .rst(rst), .all_inputs(all_inputs),
        .cfg_en(cfg_en), .cfg_din(dout0), .cfg_load(cfg_load),
        .cfg_dout(dout1), .cfg_valid(valid1), .leOut(le1)
    );

    function automatic logic [CFG_W-1:0] make_cfg(input logic [15:0] tt,
                                                 input logic [5:0] s0, input logic [5:0] s1,
                                                 input logic [5:0] s2, input logic [5:0] s3,
                                                 input logic [1:0] mode, input logic init);
        logic [CFG_W-1:0] w;
        w = '0;
        w[15:0]  = tt;
        w[21:16] = s0;
        w[27:22] = s1;
        w[33:28] = s2;
        w[39:34] = s3;
        w[41:40] = mode;
        w[42]    = init;
        return w;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic shift_word(input logic [CFG_W-1:0] w);
        for (int i = CFG_W - 1; i >= 0; i--) begin
            cfg_en  = 1'b1;
            cfg_din = w[i];
            tick();
        end
        cfg_en  = 1'b0;
        cfg_din = 1'b0;
    endtask

    task automatic commit();
        cfg_load = 1'b1;
        tick();
        cfg_load = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        all_inputs = 33'h1_DEAD_BEEF;
        #2;
        total++; if (valid0 !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", valid0); end
        total++; if (le0 !== 1'b0)    begin bad++; $display("FAIL reset_leout got=%b exp=0", le0); end
        total++; if (dout0 !== 1'b0)  begin bad++; $display("FAIL reset_dout got=%b exp=0", dout0); end
        tick(); tick();
        all_inputs = 33'h0_1234_5678;
        #1;
        total++; if (le0 !== 1'b0) begin bad++; $display("FAIL reset_leout2 got=%b exp=0", le0); end
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_and2_comb();
        logic exp;
        all_inputs = '1;
        shift_word(make_cfg(16'h8888, 6'd5, 6'd9, 6'd63, 6'd63, 2'b00, 1'b0));
        total++; if (le0 !== 1'b0)    begin bad++; $display("FAIL precommit_leout got=%b exp=0", le0); end
        total++; if (valid0 !== 1'b0) begin bad++; $display("FAIL precommit_valid got=%b exp=0", valid0); end
        commit();
        total++; if (valid0 !== 1'b1) begin bad++; $display("FAIL commit_valid got=%b exp=1", valid0); end
        for (int c = 0; c < 4; c++) begin
            all_inputs = '1;
            all_inputs[5] = c[0];
            all_inputs[9] = c[1];
            exp = c[0] & c[1];
            #1;
            total++; if (le0 !== exp) begin bad++; $display("FAIL and2_c%0d got=%b exp=%b", c, le0, exp); end
        end
    endtask

    task automatic test_dff();
        logic [3:0] pat;
        pat = 4'b0110;
        all_inputs = '0;
        shift_word(make_cfg(16'hAAAA, 6'd0, 6'd63, 6'd63, 6'd63, 2'b01, 1'b1));
        commit();
        total++; if (le0 !== 1'b1) begin bad++; $display("FAIL dff_init got=%b exp=1", le0); end
        for (int k = 0; k < 4; k++) begin
            all_inputs[0] = pat[k];
            #1;
            if (k == 0) begin
                total++; if (le0 !== 1'b1) begin bad++; $display("FAIL dff_latency got=%b exp=1", le0); end
            end
            tick();
            total++; if (le0 !== pat[k]) begin bad++; $display("FAIL dff_track%0d got=%b exp=%b", k, le0, pat[k]); end
        end
    endtask

    task automatic test_tff_hold();
        logic [3:0] exp_seq;
        exp_seq = 4'b1010;
        shift_word(make_cfg(16'hFFFF, 6'd63, 6'd63, 6'd63, 6'd63, 2'b10, 1'b0));
        commit();
        for (int k = 0; k < 4; k++) begin
            total++; if (le0 !== exp_seq[k]) begin bad++; $display("FAIL tff_step%0d got=%b exp=%b", k, le0, exp_seq[k]); end
            tick();
        end
        shift_word(make_cfg(16'hFFFF, 6'd63, 6'd63, 6'd63, 6'd63, 2'b11, 1'b1));
        commit();
        for (int k = 0; k < 3; k++) begin
            total++; if (le0 !== 1'b1) begin bad++; $display("FAIL hold_step%0d got=%b exp=1", k, le0); end
            tick();
        end
    endtask

    task automatic test_shift_and_load();
        shift_word(make_cfg(16'h8888, 6'd5, 6'd9, 6'd63, 6'd63, 2'b00, 1'b0));
        all_inputs = '0;
        all_inputs[5] = 1'b1;
        all_inputs[9] = 1'b1;
        cfg_en = 1'b1; cfg_din = 1'b1; cfg_load = 1'b1;
        tick();
        cfg_en = 1'b0; cfg_din = 1'b0; cfg_load = 1'b0;
        // Pre-shift word is COMB AND2: output is 1 at once and stays 1.
        total++; if (le0 !== 1'b1) begin bad++; $display("FAIL same_cycle_leout got=%b exp=1", le0); end
        total++; if (dout0 !== 1'b0) begin bad++; $display("FAIL same_cycle_dout got=%b exp=0", dout0); end
        all_inputs[9] = 1'b0;
        #1;
        total++; if (le0 !== 1'b0) begin bad++; $display("FAIL same_cycle_comb got=%b exp=0", le0); end
        all_inputs[9] = 1'b1;
        #1;
    endtask

    task automatic test_chain();
        logic [CFG_W-1:0] wa, wb;
        logic le1_before;
        wa = make_cfg(16'hAAAA, 6'd0, 6'd63, 6'd63, 6'd63, 2'b01, 1'b0);
        wb = make_cfg(16'h6666, 6'd1, 6'd2, 6'd63, 6'd63, 2'b00, 1'b0);
        all_inputs = '0;
        all_inputs[5] = 1'b1;
        all_inputs[9] = 1'b1;
        all_inputs[1] = 1'b1;
        #1;
        le1_before = le1;
        for (int i = 2 * CFG_W - 1; i >= 0; i--) begin
            cfg_en  = 1'b1;
            cfg_din = (i >= CFG_W) ? wb[i - CFG_W] : wa[i];
            tick();
            total++; if (le0 !== 1'b1) begin bad++; $display("FAIL chain_shift_le0 bit%0d got=%b exp=1", i, le0); end
            total++; if (le1 !== le1_before) begin bad++; $display("FAIL chain_shift_le1 bit%0d got=%b exp=%b", i, le1, le1_before); end
        end
        cfg_en = 1'b0;
        commit();
        total++; if (le0 !== 1'b0)    begin bad++; $display("FAIL chain_dut0_init got=%b exp=0", le0); end
        total++; if (valid1 !== 1'b1) begin bad++; $display("FAIL chain_dut1_valid got=%b exp=1", valid1); end
        total++; if (le1 !== 1'b1)    begin bad++; $display("FAIL chain_dut1_xor10 got=%b exp=1", le1); end
        all_inputs[2] = 1'b1;
        #1;
        total++; if (le1 !== 1'b0)    begin bad++; $display("FAIL chain_dut1_xor11 got=%b exp=0", le1); end
        all_inputs[0] = 1'b1;
        tick();
        total++; if (le0 !== 1'b1)    begin bad++; $display("FAIL chain_dut0_dff got=%b exp=1", le0); end
    endtask

    task automatic test_reset_mid_shift();
        for (int i = 0; i < 45; i++) begin
            cfg_en = 1'b1;
            cfg_din = 1'b1;
            tick();
        end
        total++; if (dout0 !== 1'b1) begin bad++; $display("FAIL midshift_dout got=%b exp=1", dout0); end
        total++; if (le0 !== 1'b1)   begin bad++; $display("FAIL midshift_le0 got=%b exp=1", le0); end
        #2;
        rst = 1'b1;
        #1;
        total++; if (le0 !== 1'b0)    begin bad++; $display("FAIL async_rst_le0 got=%b exp=0", le0); end
        total++; if (valid0 !== 1'b0) begin bad++; $display("FAIL async_rst_valid0 got=%b exp=0", valid0); end
        total++; if (valid1 !== 1'b0) begin bad++; $display("FAIL async_rst_valid1 got=%b exp=0", valid1); end
        total++; if (dout0 !== 1'b0)  begin bad++; $display("FAIL async_rst_dout got=%b exp=0", dout0); end
        cfg_en = 1'b0;
        cfg_din = 1'b0;
        tick();
        rst = 1'b0;
        tick();
        total++; if (valid0 !== 1'b0) begin bad++; $display("FAIL post_rst_valid got=%b exp=0", valid0); end
    endtask

    initial begin
        test_reset();
        test_and2_comb();
        test_dff();
        test_tff_hold();
        test_shift_and_load();
        test_chain();
        test_reset_mid_shift();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
